vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 10'd640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 10'd16, meaning horizontal front porch in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 10'd96, meaning hsync pulse width in pixels.
REQ-004 The block SHALL have parameter H_BP, default 10'd48, meaning horizontal back porch in pixels.
REQ-005 The block SHALL have parameter V_VISIBLE, default 10'd480, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10'd10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 10'd2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 10'd33, meaning vertical back porch in lines.
REQ-009 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-010 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-011 The block SHALL have port x_pos, output, 10 bits: current horizontal count, fed to the sprite stages.
REQ-012 The block SHALL have port y_pos, output, 10 bits: current vertical count, fed to the sprite stages.
REQ-013 The block SHALL have port hsync_n, output, 1 bit: horizontal sync, active low.
REQ-014 The block SHALL have port vsync_n, output, 1 bit: vertical sync, active low.
REQ-015 The block SHALL have port video_on, output, 1 bit: high while (x_pos, y_pos) is inside the visible area.
REQ-016 The block SHALL have port pix_en, output, 1 bit: pixel-advance strobe, also driven to the DAC clock.
REQ-017 The block SHALL have port frame_tick, output, 1 bit: one-clk pulse at end of frame, used by game logic.

Function
REQ-018 The horizontal counter h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 by default), advancing by one only in cycles with pix_en=1.
REQ-019 When h_cnt=H_TOTAL-1 and pix_en=1, h_cnt SHALL wrap to 0 and the vertical counter v_cnt SHALL advance by one.
REQ-020 v_cnt SHALL count 0..V_TOTAL-1 (525 by default) and wrap to 0 when it is at V_TOTAL-1 and h_cnt wraps in the same cycle.
REQ-021 x_pos SHALL equal h_cnt and y_pos SHALL equal v_cnt, with no added latency.
REQ-022 hsync_n SHALL be 0 iff H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC (656..751 by default).
REQ-023 vsync_n SHALL be 0 iff V_VISIBLE+V_FP <= v_cnt < V_VISIBLE+V_FP+V_SYNC (490..491 by default).
REQ-024 video_on SHALL be 1 iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE.
REQ-025 hsync_n, vsync_n and video_on SHALL all be decoded from the same registered counters, so they are mutually consistent with x_pos/y_pos in every cycle.
REQ-026 frame_tick SHALL be 1 for exactly one clk, in the cycle where pix_en=1, h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1; otherwise frame_tick SHALL be 0.
REQ-027 The counters SHALL never hold a value at or above their total; no out-of-range state is reachable.

Reset
REQ-028 When reset=1 at a clk edge, h_cnt, v_cnt and the pixel divider SHALL all go to 0, overriding any pending advance.
REQ-029 While reset is held, and in the cycle after release, the outputs SHALL be: x_pos=0, y_pos=0, hsync_n=1, vsync_n=1, video_on=1, frame_tick=0, pix_en=0.
REQ-030 A reset asserted mid-line or mid-frame SHALL restart timing at (0,0) with no partial sync pulse retained.

Configuration
REQ-031 The macro VGA_CLKDIV_EN SHALL control the pixel rate: when defined, pix_en is a registered toggle that is 1 on every second clk (50 MHz clk gives a 25 MHz pixel rate), starting at 0 after reset; when undefined, pix_en=1 in every cycle after reset and counters advance every clk.

Verification
REQ-032 The bench SHALL cover: reset for 3 clks then release -> x_pos=0, y_pos=0, hsync_n=1, vsync_n=1, video_on=1, frame_tick=0.
REQ-033 The bench SHALL cover: run one full line with the defaults -> hsync_n low for exactly 96 pixel strobes starting at x_pos=656, and video_on falls at x_pos=640.
REQ-034 The bench SHALL cover: run a full frame -> vsync_n low only on y_pos 490..491, and exactly one frame_tick per 800*525=420000 pixel strobes.
REQ-035 The bench SHALL cover: wrap at (799,524) -> the next strobe gives (0,0), and frame_tick is high only in the wrapping cycle.
REQ-036 The bench SHALL cover: reset asserted at (700,300) -> (0,0) on the next clk, hsync_n=1 immediately.
REQ-037 The bench SHALL cover: with VGA_CLKDIV_EN defined -> x_pos advances once per 2 clks and pix_en alternates 0,1 from reset; with it undefined -> x_pos advances every clk.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running horizontal/vertical counters with
// sync, blanking and end-of-frame decode taken straight from the registered counts.
// Optional feature macro: VGA_CLKDIV_EN -- when defined, pixels advance on every
// second clk (registered divide-by-two strobe); otherwise on every clk after reset.
module vga_timing_gen #(
  parameter logic [9:0] H_VISIBLE = 10'd640,
  parameter logic [9:0] H_FP      = 10'd16,
  parameter logic [9:0] H_SYNC    = 10'd96,
  parameter logic [9:0] H_BP      = 10'd48,
  parameter logic [9:0] V_VISIBLE = 10'd480,
  parameter logic [9:0] V_FP      = 10'd10,
  parameter logic [9:0] V_SYNC    = 10'd2,
  parameter logic [9:0] V_BP      = 10'd33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       video_on,
  output logic       pix_en,
  output logic       frame_tick
);

  localparam logic [9:0] HTotal   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] VTotal   = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] HLast    = HTotal - 10'd1;
  localparam logic [9:0] VLast    = VTotal - 10'd1;
  localparam logic [9:0] HsStart  = H_VISIBLE + H_FP;
  localparam logic [9:0] HsEnd    = H_VISIBLE + H_FP + H_SYNC;
  localparam logic [9:0] VsStart  = V_VISIBLE + V_FP;
  localparam logic [9:0] VsEnd    = V_VISIBLE + V_FP + V_SYNC;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       pix_en_q, pix_en_d;
  logic       h_last, v_last;

  assign h_last = (h_cnt_q == HLast);
  assign v_last = (v_cnt_q == VLast);

  // Pixel strobe: toggles for a halved pixel rate, else held high once out of reset.
  always_comb begin
`ifdef VGA_CLKDIV_EN
    pix_en_d = ~pix_en_q;
`else
    pix_en_d = 1'b1;
`endif
  end

  // Raster advance: step h on each strobe, step v when h wraps, wrap v at frame end.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_q) begin
      if (h_last) begin
        h_cnt_d = 10'd0;
        v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // State registers; reset wins over any pending advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q  <= 10'd0;
      v_cnt_q  <= 10'd0;
      pix_en_q <= 1'b0;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      pix_en_q <= pix_en_d;
    end
  end

  // All decodes come from the same registered counts, so they always agree with x/y.
  always_comb begin
    x_pos      = h_cnt_q;
    y_pos      = v_cnt_q;
    hsync_n    = ~((h_cnt_q >= HsStart) && (h_cnt_q < HsEnd));
    vsync_n    = ~((v_cnt_q >= VsStart) && (v_cnt_q < VsEnd));
    video_on   = (h_cnt_q < H_VISIBLE) && (v_cnt_q < V_VISIBLE);
    pix_en     = pix_en_q;
    frame_tick = pix_en_q && h_last && v_last;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance A uses the default 640x480 timing; instance B
// uses a tiny 15x12 raster so whole frames, wraps and mid-frame resets fit in a short run.
// Every cycle both instances are compared with a model that only counts pixel strobes
// since reset and derives position and decodes by modular arithmetic.
module tb_vga_timing_gen;

  localparam int SHV = 8;
  localparam int SHF = 2;
  localparam int SHS = 3;
  localparam int SHB = 2;
  localparam int SVV = 5;
  localparam int SVF = 2;
  localparam int SVS = 2;
  localparam int SVB = 3;
  localparam int SHT = SHV + SHF + SHS + SHB;  // 15
  localparam int SVT = SVV + SVF + SVS + SVB;  // 12
`ifdef VGA_CLKDIV_EN
  localparam bit DIV = 1'b1;
`else
  localparam bit DIV = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [9:0] x_a, y_a, x_b, y_b;
  logic       hs_a, vs_a, vo_a, pe_a, ft_a;
  logic       hs_b, vs_b, vo_b, pe_b, ft_b;

  vga_timing_gen dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .x_pos      (x_a),
    .y_pos      (y_a),
    .hsync_n    (hs_a),
    .vsync_n    (vs_a),
    .video_on   (vo_a),
    .pix_en     (pe_a),
    .frame_tick (ft_a)
  );

  vga_timing_gen #(
    .H_VISIBLE (10'd8),
    .H_FP      (10'd2),
    .H_SYNC    (10'd3),
    .H_BP      (10'd2),
    .V_VISIBLE (10'd5),
    .V_FP      (10'd2),
    .V_SYNC    (10'd2),
    .V_BP      (10'd3)
  ) dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .x_pos      (x_b),
    .y_pos      (y_b),
    .hsync_n    (hs_b),
    .vsync_n    (vs_b),
    .video_on   (vo_b),
    .pix_en     (pe_b),
    .frame_tick (ft_b)
  );

  int g_hv[2] = '{640, SHV};
  int g_hf[2] = '{16, SHF};
  int g_hs[2] = '{96, SHS};
  int g_vv[2] = '{480, SVV};
  int g_vf[2] = '{10, SVF};
  int g_vs[2] = '{2, SVS};
  int g_ht[2] = '{800, SHT};
  int g_vt[2] = '{525, SVT};

  // Model state: strobes consumed since reset, expected strobe level, model valid.
  int m_n[2]  = '{0, 0};
  bit m_pe[2] = '{1'b0, 1'b0};
  bit m_ok[2] = '{1'b0, 1'b0};

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic void model_edge(int i, bit r);
    if (r) begin
      m_n[i]  = 0;
      m_pe[i] = 1'b0;
      m_ok[i] = 1'b1;
    end else if (m_ok[i]) begin
      if (m_pe[i]) m_n[i]++;
      m_pe[i] = DIV ? !m_pe[i] : 1'b1;
    end
  endfunction

  function automatic void check_model(int i, logic [9:0] x, logic [9:0] y, logic hs,
                                      logic vs, logic vo, logic pe, logic ft);
    int ex, ey;
    bit ehs, evs, evo, eft;
    string t;
    if (!m_ok[i]) return;
    t   = (i == 0) ? "A" : "B";
    ex  = m_n[i] % g_ht[i];
    ey  = (m_n[i] / g_ht[i]) % g_vt[i];
    ehs = !((ex >= g_hv[i] + g_hf[i]) && (ex < g_hv[i] + g_hf[i] + g_hs[i]));
    evs = !((ey >= g_vv[i] + g_vf[i]) && (ey < g_vv[i] + g_vf[i] + g_vs[i]));
    evo = (ex < g_hv[i]) && (ey < g_vv[i]);
    eft = m_pe[i] && (ex == g_ht[i] - 1) && (ey == g_vt[i] - 1);
    chk({t, " model x_pos"}, 32'(x), ex);
    chk({t, " model y_pos"}, 32'(y), ey);
    chk({t, " model hsync_n"}, 32'(hs), 32'(ehs));
    chk({t, " model vsync_n"}, 32'(vs), 32'(evs));
    chk({t, " model video_on"}, 32'(vo), 32'(evo));
    chk({t, " model pix_en"}, 32'(pe), 32'(m_pe[i]));
    chk({t, " model frame_tick"}, 32'(ft), 32'(eft));
  endfunction

  task automatic tick();
    bit ra, rb;
    ra = rst_a;
    rb = rst_b;
    @(posedge clk);
    model_edge(0, ra);
    model_edge(1, rb);
    #1;
    check_model(0, x_a, y_a, hs_a, vs_a, vo_a, pe_a, ft_a);
    check_model(1, x_b, y_b, hs_b, vs_b, vo_b, pe_b, ft_b);
  endtask

  task automatic run_b_until(int ex, int ey, bit need_pe, string name);
    bit found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (x_b == 10'(ex) && y_b == 10'(ey) && (!need_pe || pe_b)) found = 1'b1;
      else tick();
    end
    chk({name, " reached"}, 32'(found), 1);
  endtask

  typedef struct {
    int strobes;
    int x, y;
    bit hs, vs, vo;
  } vec_t;

  initial begin
    vec_t vecs[15];
    int   s, guard, hs_low, first_hs_x, vo_fall_x, ft_cnt, ft_bad, vs_low, vs_bad;
    bit   found;

    vecs[0]  = '{0,   0,  0, 1, 1, 1};
    vecs[1]  = '{7,   7,  0, 1, 1, 1};
    vecs[2]  = '{8,   8,  0, 1, 1, 0};
    vecs[3]  = '{10,  10, 0, 0, 1, 0};
    vecs[4]  = '{12,  12, 0, 0, 1, 0};
    vecs[5]  = '{13,  13, 0, 1, 1, 0};
    vecs[6]  = '{15,  0,  1, 1, 1, 1};
    vecs[7]  = '{74,  14, 4, 1, 1, 0};
    vecs[8]  = '{75,  0,  5, 1, 1, 0};
    vecs[9]  = '{105, 0,  7, 1, 0, 0};
    vecs[10] = '{134, 14, 8, 1, 0, 0};
    vecs[11] = '{135, 0,  9, 1, 1, 0};
    vecs[12] = '{179, 14, 11, 1, 1, 0};
    vecs[13] = '{180, 0,  0, 1, 1, 1};
    vecs[14] = '{190, 10, 0, 0, 1, 0};

    // Reset held three clocks, then the first cycle after release.
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) tick();
      else begin
        rst_a = 1'b0;
        rst_b = 1'b0;
      end
      chk("reset x_pos", 32'(x_a), 0);
      chk("reset y_pos", 32'(y_a), 0);
      chk("reset hsync_n", 32'(hs_a), 1);
      chk("reset vsync_n", 32'(vs_a), 1);
      chk("reset video_on", 32'(vo_a), 1);
      chk("reset frame_tick", 32'(ft_a), 0);
      chk("reset pix_en", 32'(pe_a), 0);
    end

    // Strobe cadence and x advance rate right after release.
    for (int k = 0; k < 8; k++) begin
      chk("cadence pix_en", 32'(pe_a), DIV ? 32'(k % 2) : ((k == 0) ? 0 : 1));
      chk("cadence x_pos", 32'(x_a), DIV ? 32'(k / 2) : ((k == 0) ? 0 : 32'(k - 1)));
      tick();
    end

    // One full default line: hsync window and blanking edge.
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    s = 0; guard = 0; hs_low = 0; first_hs_x = -1; vo_fall_x = -1;
    while (s < 800 && guard < 4000) begin
      if (pe_a) begin
        if (!hs_a) begin
          hs_low++;
          if (first_hs_x < 0) first_hs_x = int'(x_a);
        end
        if (!vo_a && vo_fall_x < 0) vo_fall_x = int'(x_a);
        s++;
      end
      tick();
      guard++;
    end
    chk("line strobes", s, 800);
    chk("line hsync low strobes", hs_low, 96);
    chk("line hsync first x", first_hs_x, 656);
    chk("line video_on fall x", vo_fall_x, 640);
    chk("line wrap x_pos", 32'(x_a), 0);
    chk("line wrap y_pos", 32'(y_a), 1);

    // Mid-line reset on the default raster while hsync is active.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (x_a == 10'd700) found = 1'b1;
      else tick();
    end
    chk("A x=700 reached", 32'(found), 1);
    chk("A x=700 hsync_n", 32'(hs_a), 0);
    rst_a = 1'b1;
    tick();
    chk("A midreset x_pos", 32'(x_a), 0);
    chk("A midreset y_pos", 32'(y_a), 0);
    chk("A midreset hsync_n", 32'(hs_a), 1);
    rst_a = 1'b0;

    // Table of strobe counts on the small raster.
    foreach (vecs[v]) begin
      rst_b = 1'b1;
      tick();
      tick();
      rst_b = 1'b0;
      s = 0; guard = 0;
      while (s < vecs[v].strobes && guard < 1000) begin
        if (pe_b) s++;
        tick();
        guard++;
      end
      chk($sformatf("vec%0d strobes", v), s, vecs[v].strobes);
      chk($sformatf("vec%0d x_pos", v), 32'(x_b), vecs[v].x);
      chk($sformatf("vec%0d y_pos", v), 32'(y_b), vecs[v].y);
      chk($sformatf("vec%0d hsync_n", v), 32'(hs_b), 32'(vecs[v].hs));
      chk($sformatf("vec%0d vsync_n", v), 32'(vs_b), 32'(vecs[v].vs));
      chk($sformatf("vec%0d video_on", v), 32'(vo_b), 32'(vecs[v].vo));
    end

    // Two whole small frames: one tick per frame, vsync only on its lines.
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    s = 0; guard = 0; ft_cnt = 0; ft_bad = 0; vs_low = 0; vs_bad = 0;
    while (s < 2 * SHT * SVT && guard < 3000) begin
      if (ft_b) begin
        ft_cnt++;
        if (!(x_b == 10'(SHT - 1) && y_b == 10'(SVT - 1) && pe_b)) ft_bad++;
      end
      if (!vs_b && (y_b < 10'(SVV + SVF) || y_b >= 10'(SVV + SVF + SVS))) vs_bad++;
      if (pe_b) begin
        if (!vs_b) vs_low++;
        s++;
      end
      tick();
      guard++;
    end
    chk("frame strobes", s, 2 * SHT * SVT);
    chk("frame tick count", ft_cnt, 2);
    chk("frame tick misplaced", ft_bad, 0);
    chk("frame vsync low strobes", vs_low, 2 * SVS * SHT);
    chk("frame vsync outside lines", vs_bad, 0);

    // Wrap at the last pixel of the last line.
    run_b_until(SHT - 1, SVT - 1, 1'b1, "B last pixel");
    chk("wrap frame_tick high", 32'(ft_b), 1);
    tick();
    chk("wrap x_pos", 32'(x_b), 0);
    chk("wrap y_pos", 32'(y_b), 0);
    chk("wrap frame_tick low", 32'(ft_b), 0);

    // Mid-frame reset with both syncs active.
    run_b_until(12, 7, 1'b0, "B (12,7)");
    chk("B (12,7) hsync_n", 32'(hs_b), 0);
    chk("B (12,7) vsync_n", 32'(vs_b), 0);
    rst_b = 1'b1;
    tick();
    chk("B midreset x_pos", 32'(x_b), 0);
    chk("B midreset y_pos", 32'(y_b), 0);
    chk("B midreset hsync_n", 32'(hs_b), 1);
    chk("B midreset vsync_n", 32'(vs_b), 1);
    rst_b = 1'b0;

    // Random run lengths and reset pulses; the per-cycle model does the checking.
    for (int it = 0; it < 24; it++) begin
      int len;
      int which;
      len   = int'($urandom_range(1, 400));
      which = int'($urandom_range(0, 2));
      repeat (len) tick();
      if (which != 1) rst_a = 1'b1;
      if (which != 0) rst_b = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      rst_a = 1'b0;
      rst_b = 1'b0;
    end
    repeat (50) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
